// File: rtl/de2_70_ethernet_nios2_div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and default width.
package de2_70_ethernet_nios2_div_pkg;

  localparam int unsigned DIV_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/de2_70_ethernet_nios2_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor magnitude, keep the difference when non-negative.
module de2_70_ethernet_nios2_div_step
  import de2_70_ethernet_nios2_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH:0]   i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_sub;
  logic             w_ge;

  // One guard bit above the remainder keeps the shifted value exact.
  assign w_shift = {i_rem, i_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_div});
  assign w_sub   = w_shift - {1'b0, i_div};

  always_comb begin
    o_rem = (WIDTH+1)'(w_shift);
    o_q   = {i_q[WIDTH-2:0], 1'b0};
    if (w_ge) begin
      o_rem = (WIDTH+1)'(w_sub);
      o_q   = {i_q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/de2_70_ethernet_nios2_qsys_0_div_cell.sv
// Multi-cycle signed/unsigned divider: magnitude restoring division over WIDTH
// cycles followed by a sign-fix cycle and a one-cycle done pulse.
module de2_70_ethernet_nios2_qsys_0_div_cell
  import de2_70_ethernet_nios2_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  input  logic             A_div_signed,
  input  logic             A_div_start,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quot,
  output logic [WIDTH-1:0] A_div_rem
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem, r_div;
  logic [WIDTH-1:0] r_q, r_src1, r_quot, r_remo;
  logic             r_neg_q, r_neg_r, r_div0, r_ovf;

  logic             w_s1_neg, w_s2_neg;
  logic [WIDTH:0]   w_ext1, w_ext2, w_mag1, w_mag2;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // Magnitudes are formed one bit wider so |most-negative| stays representable.
  assign w_s1_neg = A_div_signed & A_div_src1[WIDTH-1];
  assign w_s2_neg = A_div_signed & A_div_src2[WIDTH-1];
  assign w_ext1   = {w_s1_neg, A_div_src1};
  assign w_ext2   = {w_s2_neg, A_div_src2};
  assign w_mag1   = w_s1_neg ? -w_ext1 : w_ext1;
  assign w_mag2   = w_s2_neg ? -w_ext2 : w_ext2;

  de2_70_ethernet_nios2_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_q   (r_q),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (A_div_start) w_state_nxt = S_RUN;
      S_RUN:  if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign A_div_busy = (r_state != S_IDLE);
  assign A_div_done = (r_state == S_DONE);
  assign A_div_quot = r_quot;
  assign A_div_rem  = r_remo;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_src1  <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (A_div_start) begin
          r_src1  <= A_div_src1;
          r_q     <= WIDTH'(w_mag1);
          r_div   <= w_mag2;
          r_rem   <= '0;
          r_cnt   <= CW'(WIDTH - 1);
          r_neg_q <= w_s1_neg ^ w_s2_neg;
          r_neg_r <= w_s1_neg;
          r_div0  <= (A_div_src2 == '0);
          r_ovf   <= A_div_signed & (A_div_src1 == MOST_NEG) & (A_div_src2 == '1);
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          // Special cases override the sign-corrected magnitude result.
          if (r_div0) begin
            r_quot <= '1;
            r_remo <= r_src1;
          end else if (r_ovf) begin
            r_quot <= MOST_NEG;
            r_remo <= '0;
          end else begin
            r_quot <= r_neg_q ? -r_q : r_q;
            r_remo <= r_neg_r ? -WIDTH'(r_rem) : WIDTH'(r_rem);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/de2_70_ethernet_nios2_qsys_0_div_cell.md
DE2_70_ETHERNET_NIOS2_QSYS_0_DIV_CELL -- requirements
Module: de2_70_ethernet_nios2_qsys_0_div_cell

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand, quotient and remainder width.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-004 Port A_div_src1, input, WIDTH: dividend.
REQ-005 Port A_div_src2, input, WIDTH: divisor.
REQ-006 Port A_div_signed, input, 1: 1 selects two's-complement division, 0 selects unsigned.
REQ-007 Port A_div_start, input, 1: request strobe; operands and A_div_signed are sampled on the same edge.
REQ-008 Port A_div_busy, output, 1: high while an operation is in flight.
REQ-009 Port A_div_done, output, 1: single-cycle pulse marking valid results.
REQ-010 Port A_div_quot, output, WIDTH: quotient.
REQ-011 Port A_div_rem, output, WIDTH: remainder.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FIX and DONE.
REQ-013 In IDLE with A_div_start=1, the block SHALL latch the operand magnitudes, signs, mode and special-case flags, clear the partial remainder, load the iteration counter with WIDTH-1, and enter RUN.
REQ-014 RUN SHALL perform one radix-2 restoring step per cycle (shift remainder left, subtract divisor magnitude, keep the result if non-negative and set the quotient bit), moving to FIX after exactly WIDTH cycles.
REQ-015 FIX SHALL apply sign correction: quotient negated if the operand signs differ; remainder takes the dividend's sign. FIX then enters DONE.
REQ-016 DONE SHALL assert A_div_done for exactly one cycle and return to IDLE.
REQ-017 Latency: with start sampled at edge 0, A_div_done SHALL be high in cycle WIDTH+2 (34 for WIDTH=32).
REQ-018 A_div_quot and A_div_rem SHALL be registered, SHALL update only on entry to DONE, and SHALL hold until the next DONE.
REQ-019 A_div_busy SHALL be high from the cycle after start through the DONE cycle inclusive.
REQ-020 A_div_start SHALL be ignored while busy; operands SHALL NOT be re-sampled.
REQ-021 Start in the DONE cycle SHALL be ignored; the earliest accepted restart is the first IDLE cycle.
REQ-022 Divide by zero SHALL give quot = all ones and rem = dividend, in either mode, with the normal latency.
REQ-023 Signed overflow (most-negative value divided by -1) SHALL give quot = most-negative value and rem = 0, with the normal latency.
REQ-024 Internal magnitude and remainder arithmetic SHALL be WIDTH+1 bits wide so that the magnitude of the most-negative value does not overflow.

Reset
REQ-025 While reset_n=0 at a clock edge, the FSM SHALL go to IDLE and busy, done, quot, rem and the counter SHALL all be cleared to 0.
REQ-026 Reset asserted mid-operation SHALL abort the operation: no done pulse and no result update.

Structure
REQ-027 Package de2_70_ethernet_nios2_div_pkg SHALL hold the FSM state encoding and the default-width constant.
REQ-028 The single-step compare/subtract/shift datapath SHALL be one combinational sub-module, de2_70_ethernet_nios2_div_step, instanced once.

Verification
REQ-029 Unsigned 100/7 -> quot=14, rem=2, done in cycle 34, busy high cycles 1-34.
REQ-030 Signed 0xFFFFFF9C/7 (-100/7) -> quot=0xFFFFFFF2, rem=0xFFFFFFFE; signed 100/0xFFFFFFF9 -> quot=0xFFFFFFF2, rem=2.
REQ-031 0x12345678/0 (both modes) -> quot=0xFFFFFFFF, rem=0x12345678.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0; unsigned same operands -> quot=0, rem=0x80000000.
REQ-033 Second start at cycle 5 with different operands -> ignored; the first result still arrives at cycle 34.
REQ-034 reset_n low at cycle 10 -> busy=0 at cycle 11, no done; a new start is accepted at the first cycle after reset_n returns high.
